// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - per-frame player/obstacle overlap scan with lives and grace tracking
// Slot i of obstacles_in is bits [16*i +: 16] = {active, lane[1:0], position[10:0], sprite_type[1:0]}.
module collision_detector #(
    parameter logic [10:0] PLAYER_X       = 11'd128,
    parameter logic [10:0] PLAYER_WIDTH   = 11'd32,
    parameter logic [10:0] OBSTACLE_WIDTH = 11'd64,
    parameter logic [1:0]  START_LIVES    = 2'd3,
    parameter logic [5:0]  GRACE_FRAMES   = 6'd60
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         game_reset,
    input  logic         frame_trigger,
    input  logic [159:0] obstacles_in,
    input  logic [1:0]   lane_in,
    input  logic         jump_in,
    output logic         collision_out,
    output logic [3:0]   hit_index,
    output logic [1:0]   lives_out,
    output logic         game_over,
    output logic         busy
);

    localparam int         SLOT_W    = 16;
    localparam logic [3:0] LAST_SLOT = 4'd9;

    // Overlap window on the obstacle right edge, widened to 12 bits so the sum cannot wrap.
    localparam logic [11:0] HIT_LO = {1'b0, PLAYER_X};
    localparam logic [11:0] HIT_HI = {1'b0, PLAYER_X} + {1'b0, PLAYER_WIDTH} + {1'b0, OBSTACLE_WIDTH};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SCAN,
        S_RESOLVE,
        S_DEAD
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [159:0]   r_snap_obs;
    logic [1:0]     r_snap_lane;
    logic           r_snap_jump;
    logic [3:0]     r_scan_idx;
    logic           r_hit_found;
    logic [3:0]     r_hit_slot;
    logic [5:0]     r_grace;
    logic [1:0]     r_lives;
    logic           r_collision;
    logic [3:0]     r_hit_index;
    logic           r_game_over;

    logic           w_reset;
    logic [SLOT_W-1:0] w_slot;
    logic [11:0]    w_pos12;
    logic           w_slot_hit;
    logic           w_count_hit;
    logic [1:0]     w_lives_after;

    assign w_reset = rst_in | game_reset;

    assign w_slot  = r_snap_obs[{r_scan_idx, 4'b0000} +: SLOT_W];
    assign w_pos12 = {1'b0, w_slot[12:2]};

    // Ground-level sprites (sprite_type[1] == 0) are cleared by jumping.
    assign w_slot_hit = w_slot[15]
                     && (w_slot[14:13] == r_snap_lane)
                     && (w_pos12 > HIT_LO)
                     && (w_pos12 < HIT_HI)
                     && !(!w_slot[1] && r_snap_jump);

    assign w_count_hit = (r_state == S_RESOLVE) && r_hit_found
                      && (r_grace == 6'd0) && (r_lives != 2'd0);

    assign w_lives_after = w_count_hit ? (r_lives - 2'd1) : r_lives;

    always_ff @(posedge clk_in) begin
        if (w_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_trigger) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_state_next = S_SCAN;
            end
            S_SCAN: begin
                if (r_scan_idx == LAST_SLOT) begin
                    w_state_next = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                if (w_lives_after == 2'd0) begin
                    w_state_next = S_DEAD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_DEAD: begin
                w_state_next = S_DEAD;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_reset) begin
            r_snap_obs  <= '0;
            r_snap_lane <= 2'd0;
            r_snap_jump <= 1'b0;
            r_scan_idx  <= 4'd0;
            r_hit_found <= 1'b0;
            r_hit_slot  <= 4'd0;
            r_grace     <= 6'd0;
            r_lives     <= START_LIVES;
            r_collision <= 1'b0;
            r_hit_index <= 4'd0;
            r_game_over <= 1'b0;
        end else begin
            r_collision <= w_count_hit;
            case (r_state)
                S_IDLE: begin
                    if (frame_trigger && (r_grace != 6'd0)) begin
                        r_grace <= r_grace - 6'd1;
                    end
                end
                S_CAPTURE: begin
                    r_snap_obs  <= obstacles_in;
                    r_snap_lane <= lane_in;
                    r_snap_jump <= jump_in;
                    r_scan_idx  <= 4'd0;
                    r_hit_found <= 1'b0;
                    r_hit_slot  <= 4'd0;
                end
                S_SCAN: begin
                    // First hit wins; later slots of the same scan are ignored.
                    if (w_slot_hit && !r_hit_found) begin
                        r_hit_found <= 1'b1;
                        r_hit_slot  <= r_scan_idx;
                    end
                    r_scan_idx <= r_scan_idx + 4'd1;
                end
                S_RESOLVE: begin
                    if (w_count_hit) begin
                        r_hit_index <= r_hit_slot;
                        r_lives     <= w_lives_after;
                        r_grace     <= GRACE_FRAMES;
                    end
                    if (w_lives_after == 2'd0) begin
                        r_game_over <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign collision_out = r_collision;
    assign hit_index     = r_hit_index;
    assign lives_out     = r_lives;
    assign game_over     = r_game_over;
    assign busy          = (r_state == S_CAPTURE) || (r_state == S_SCAN) || (r_state == S_RESOLVE);

endmodule
